// File: rtl/eh2_dccm_port_arb_pkg.sv
// Shared types and defaults for the DCCM port arbiter and its DMA request buffer.
package eh2_dccm_port_arb_pkg;

  // Default geometry of the DCCM port and the DMA request path.
  localparam int DCCM_BITS_DEF        = 16;
  localparam int DCCM_FDATA_WIDTH_DEF = 39;
  localparam int DMA_TAG_W_DEF        = 3;
  localparam int DMA_FIFO_DEPTH_DEF   = 2;
  localparam int DMA_STARVE_MAX_DEF   = 7;

  // One buffered DMA request as held in the FIFO.
  typedef struct packed {
    logic                            write;
    logic [DCCM_BITS_DEF-1:0]        addr;
    logic [DCCM_FDATA_WIDTH_DEF-1:0] wdata;
    logic [DMA_TAG_W_DEF-1:0]        tag;
  } dma_entry_t;

  // Records who issued the read whose data returns next cycle.
  typedef struct packed {
    logic                     valid;
    logic                     is_dma;
    logic [DMA_TAG_W_DEF-1:0] tag;
  } owner_t;

endpackage

// File: rtl/eh2_dccm_arb_fifo.sv
// Small synchronous FIFO buffering DMA requests for the DCCM port arbiter.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module eh2_dccm_arb_fifo
  import eh2_dccm_port_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DMA_FIFO_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Same index with opposite wrap bits means the write side lapped the read side.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Overflow and underflow requests are ignored rather than corrupting pointers.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointer update; reset drops every buffered entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/eh2_dccm_port_arb.sv
// Arbiter for the single DCCM read/write port shared by the LSU pipe and the
// DMA slave. The LSU has priority; a saturating starvation counter forces a
// DMA grant after DMA_STARVE_MAX blocked cycles. Read data, which the DCCM
// returns one cycle after the read enable, is steered back to its issuer.
//
// DMA request handshake: a request transfers on a rising clock edge where both
// i_dma_req_valid and o_dma_req_ready are high. o_dma_req_ready depends only
// on registered FIFO state (never on a same-cycle pop) and is low in reset.
// The LSU side has no ready: o_lsu_stall=1 means the presented request was not
// taken this cycle and must be held.
module eh2_dccm_port_arb
  import eh2_dccm_port_arb_pkg::*;
#(
  parameter int DCCM_BITS        = DCCM_BITS_DEF,
  parameter int DCCM_FDATA_WIDTH = DCCM_FDATA_WIDTH_DEF,
  parameter int DMA_FIFO_DEPTH   = DMA_FIFO_DEPTH_DEF,
  parameter int DMA_STARVE_MAX   = DMA_STARVE_MAX_DEF,
  parameter int DMA_TAG_W        = DMA_TAG_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  // LSU pipe
  input  logic                        i_lsu_rden,
  input  logic                        i_lsu_wren,
  input  logic [DCCM_BITS-1:0]        i_lsu_addr_lo,
  input  logic [DCCM_BITS-1:0]        i_lsu_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] i_lsu_wdata_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] i_lsu_wdata_hi,
  output logic                        o_lsu_stall,
  output logic                        o_lsu_rd_valid,
  output logic [DCCM_FDATA_WIDTH-1:0] o_lsu_rd_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] o_lsu_rd_data_hi,
  // DMA slave
  input  logic                        i_dma_req_valid,
  output logic                        o_dma_req_ready,
  input  logic                        i_dma_req_write,
  input  logic [DCCM_BITS-1:0]        i_dma_req_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] i_dma_req_wdata,
  input  logic [DMA_TAG_W-1:0]        i_dma_req_tag,
  output logic                        o_dma_rsp_valid,
  output logic [DMA_TAG_W-1:0]        o_dma_rsp_tag,
  output logic [DCCM_FDATA_WIDTH-1:0] o_dma_rsp_data,
  // DCCM port
  output logic                        o_dccm_rden,
  output logic                        o_dccm_wren,
  output logic [DCCM_BITS-1:0]        o_dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        o_dccm_rd_addr_hi,
  output logic [DCCM_BITS-1:0]        o_dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        o_dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] o_dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] o_dccm_wr_data_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] i_dccm_rd_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] i_dccm_rd_data_hi
);

  localparam int                CNT_W      = $clog2(DMA_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_TOP = CNT_W'(DMA_STARVE_MAX);

  dma_entry_t       w_push_entry;
  dma_entry_t       w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_pop;

  logic             w_lsu_req;
  logic             w_dma_pend;
  logic             w_force_dma;
  logic             w_grant_lsu;
  logic             w_grant_dma;
  logic             w_grant_read;

  logic [CNT_W-1:0] r_starve_cnt;
  owner_t           r_owner;
  owner_t           w_owner_next;

  // ---------------------------------------------------------------------------
  // DMA request buffer
  // ---------------------------------------------------------------------------

  // Pack the incoming DMA beat into a FIFO entry.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.write = i_dma_req_write;
    w_push_entry.addr  = i_dma_req_addr;
    w_push_entry.wdata = i_dma_req_wdata;
    w_push_entry.tag   = i_dma_req_tag;
  end

  assign o_dma_req_ready = !i_rst && !w_fifo_full;
  assign w_push          = i_dma_req_valid && o_dma_req_ready;
  assign w_pop           = w_grant_dma;

  eh2_dccm_arb_fifo #(
    .WIDTH ($bits(dma_entry_t)),
    .DEPTH (DMA_FIFO_DEPTH)
  ) u_dma_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------

  // Requests are masked in reset so every port output stays quiet.
  assign w_lsu_req   = (i_lsu_rden || i_lsu_wren) && !i_rst;
  assign w_dma_pend  = !w_fifo_empty && !i_rst;
  assign w_force_dma = w_dma_pend && (r_starve_cnt == STARVE_TOP);
  assign w_grant_dma = w_dma_pend && (!w_lsu_req || w_force_dma);
  assign w_grant_lsu = w_lsu_req && !w_force_dma;
  assign o_lsu_stall = w_lsu_req && !w_grant_lsu;

  // A simultaneous LSU read+write is treated as the write.
  assign w_grant_read = (w_grant_lsu && !i_lsu_wren) ||
                        (w_grant_dma && !w_head.write);

  // Count cycles the FIFO head is left waiting; saturate at the force point.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_fifo_empty || w_grant_dma) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_TOP) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // DCCM port drive
  // ---------------------------------------------------------------------------

  // Route the granted request onto the port; an idle port drives all zeros.
  always_comb begin
    o_dccm_rden       = 1'b0;
    o_dccm_wren       = 1'b0;
    o_dccm_rd_addr_lo = '0;
    o_dccm_rd_addr_hi = '0;
    o_dccm_wr_addr_lo = '0;
    o_dccm_wr_addr_hi = '0;
    o_dccm_wr_data_lo = '0;
    o_dccm_wr_data_hi = '0;
    if (w_grant_lsu) begin
      if (i_lsu_wren) begin
        o_dccm_wren       = 1'b1;
        o_dccm_wr_addr_lo = i_lsu_addr_lo;
        o_dccm_wr_addr_hi = i_lsu_addr_hi;
        o_dccm_wr_data_lo = i_lsu_wdata_lo;
        o_dccm_wr_data_hi = i_lsu_wdata_hi;
      end else begin
        o_dccm_rden       = 1'b1;
        o_dccm_rd_addr_lo = i_lsu_addr_lo;
        o_dccm_rd_addr_hi = i_lsu_addr_hi;
      end
    end else if (w_grant_dma) begin
      // DMA beats are single-bank; the same address and data go to both banks.
      if (w_head.write) begin
        o_dccm_wren       = 1'b1;
        o_dccm_wr_addr_lo = w_head.addr;
        o_dccm_wr_addr_hi = w_head.addr;
        o_dccm_wr_data_lo = w_head.wdata;
        o_dccm_wr_data_hi = w_head.wdata;
      end else begin
        o_dccm_rden       = 1'b1;
        o_dccm_rd_addr_lo = w_head.addr;
        o_dccm_rd_addr_hi = w_head.addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return steering
  // ---------------------------------------------------------------------------

  // Capture who owns the read data arriving next cycle.
  always_comb begin
    w_owner_next        = '0;
    w_owner_next.valid  = w_grant_read;
    w_owner_next.is_dma = w_grant_read && w_grant_dma;
    w_owner_next.tag    = (w_grant_read && w_grant_dma) ? w_head.tag : '0;
  end

  // One-stage owner register matching the DCCM read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner <= '0;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // Exactly one requester sees the returning data; the other side reads zero.
  always_comb begin
    o_lsu_rd_valid   = r_owner.valid && !r_owner.is_dma && !i_rst;
    o_dma_rsp_valid  = r_owner.valid && r_owner.is_dma && !i_rst;
    o_lsu_rd_data_lo = o_lsu_rd_valid ? i_dccm_rd_data_lo : '0;
    o_lsu_rd_data_hi = o_lsu_rd_valid ? i_dccm_rd_data_hi : '0;
    o_dma_rsp_data   = o_dma_rsp_valid ? i_dccm_rd_data_lo : '0;
    o_dma_rsp_tag    = o_dma_rsp_valid ? r_owner.tag : '0;
  end

endmodule
